// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI commit monitor, plus minimal riscv/rvfi packages.
// riscv/rvfi_pkg mirror the core's own packages: XLEN, VLEN and the commit record.

package riscv;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 39;
endpackage

package rvfi_pkg;
    typedef struct packed {
        logic                     valid;
        logic                     trap;
        logic [4:0]               rd_addr;
        logic [riscv::VLEN-1:0]   pc_rdata;
        logic [riscv::XLEN-1:0]   mem_addr;
        logic [riscv::XLEN/8-1:0] mem_wmask;
        logic [riscv::XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;
endpackage

package rvfi_mon_pkg;
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        TOHOST  = 2'd1,
        TIMEOUT = 2'd2,
        HANG    = 2'd3
    } exit_reason_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned EXIT_CODE_TIMEOUT = 1;
    localparam int unsigned EXIT_CODE_HANG    = 3;

    function automatic logic [63:0] sext_pc(
        input logic [riscv::VLEN-1:0] pc
    );
        return 64'($signed(pc));
    endfunction

    // A store of a non-zero value to the (enabled) tohost address that
    // writes no register.
    function automatic logic is_tohost(
        input rvfi_pkg::rvfi_instr_t  r,
        input logic [riscv::XLEN-1:0] addr
    );
        return r.valid && (r.rd_addr == 5'd0) && (|r.mem_wmask)
            && (r.mem_addr == addr) && (|r.mem_wdata) && (|addr);
    endfunction
endpackage

// File: rtl/rvfi_pc_history.sv
// Multi-write ring buffer of 64-bit PCs; up to NR_WR writes per cycle in port order.
// Ports: en_i gates all writes, we_i/wdata_i per port, idx_i 0 = newest, rdata_o.

module rvfi_pc_history #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NR_WR = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic [NR_WR-1:0]               we_i,
    input  logic [NR_WR-1:0][63:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0]       idx_i,
    output logic [63:0]                    rdata_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][63:0] mem_q, mem_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;

    // Walking the pointer per written port keeps port 0 older than port 1.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (en_i) begin
            for (int k = 0; k < int'(NR_WR); k++) begin
                if (we_i[k]) begin
                    mem_d[wptr_d] = wdata_i[k];
                    wptr_d        = wptr_d + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps by itself.
    assign rdata_o = mem_q[wptr_q - PTR_W'(1) - idx_i];
endmodule

// File: rtl/rvfi_commit_monitor.sv
// RVFI commit monitor: counts cycles/instret/traps, detects tohost/timeout/hang
// exit, drains, then holds a sticky exit code. Ports: rvfi_i commit ports,
// tohost_addr_i/timeout_i (0 disables), exit_*_o result, *_cnt_o counters,
// hist_idx_i/hist_pc_o PC history read (only with RVFI_MON_HISTORY_EN defined).

module rvfi_commit_monitor
    import rvfi_mon_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned CNT_W           = 64,
    parameter int unsigned HANG_CYCLES     = 10000,
    parameter int unsigned DRAIN_CYCLES    = 16,
    parameter int unsigned HIST_DEPTH      = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    input  logic [riscv::XLEN-1:0]                      tohost_addr_i,
    input  logic [CNT_W-1:0]                            timeout_i,
    output logic                                        exit_valid_o,
    output logic [riscv::XLEN-1:0]                      exit_code_o,
    output exit_reason_e                                exit_reason_o,
    output logic [63:0]                                 exit_pc_o,
    output logic [CNT_W-1:0]                            cycle_cnt_o,
    output logic [CNT_W-1:0]                            instret_o,
    output logic [CNT_W-1:0]                            trap_cnt_o,
    input  logic [$clog2(HIST_DEPTH)-1:0]               hist_idx_i,
    output logic [63:0]                                 hist_pc_o
);
    localparam int unsigned INC_W   = $clog2(NR_COMMIT_PORTS + 1);
    localparam int unsigned IDLE_W  =
        (HANG_CYCLES > 0) ? $clog2(HANG_CYCLES + 1) : 1;
    localparam int unsigned DRAIN_W =
        (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DRAIN_LAST =
        (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [INC_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    state_e                 state_q, state_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic [CNT_W-1:0]       instret_q, instret_d;
    logic [CNT_W-1:0]       trap_q, trap_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [riscv::XLEN-1:0] code_q, code_d;
    exit_reason_e           reason_q, reason_d;
    logic [63:0]            pc_q, pc_d;

    logic [INC_W-1:0]       n_valid, n_trap;
    logic                   any_valid;
    logic                   th_hit, to_hit, hang_hit;
    logic [riscv::XLEN-1:0] th_code;
    logic [63:0]            th_pc;

    always_comb begin
        n_valid   = '0;
        n_trap    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            if (rvfi_i[k].valid) begin
                n_valid   = n_valid + INC_W'(1);
                any_valid = 1'b1;
            end
            if (!rvfi_i[k].valid && rvfi_i[k].trap) begin
                n_trap = n_trap + INC_W'(1);
            end
        end
    end

    // Scan from the highest port down so the lowest matching port wins.
    always_comb begin
        th_hit  = 1'b0;
        th_code = '0;
        th_pc   = '0;
        for (int k = int'(NR_COMMIT_PORTS) - 1; k >= 0; k--) begin
            if (is_tohost(rvfi_i[k], tohost_addr_i)) begin
                th_hit  = 1'b1;
                th_code = rvfi_i[k].mem_wdata;
                th_pc   = sext_pc(rvfi_i[k].pc_rdata);
            end
        end
    end

    assign to_hit   = (timeout_i != '0) && (cycle_q >= timeout_i);
    assign hang_hit = (HANG_CYCLES != 0)
                   && (idle_q == IDLE_W'(HANG_CYCLES));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        idle_d    = idle_q;
        code_d    = code_q;
        reason_d  = reason_q;
        pc_d      = pc_q;

        if (state_q != DONE) begin
            cycle_d   = sat_add(cycle_q, INC_W'(1));
            instret_d = sat_add(instret_q, n_valid);
            trap_d    = sat_add(trap_q, n_trap);
            if (any_valid) begin
                idle_d = '0;
            end else if (idle_q != '1) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        unique case (state_q)
            RUN: begin
                if (th_hit || to_hit || hang_hit) begin
                    if (th_hit) begin
                        reason_d = TOHOST;
                        code_d   = th_code;
                        pc_d     = th_pc;
                    end else if (to_hit) begin
                        reason_d = TIMEOUT;
                        code_d   = riscv::XLEN'(EXIT_CODE_TIMEOUT);
                        pc_d     = '0;
                    end else begin
                        reason_d = HANG;
                        code_d   = riscv::XLEN'(EXIT_CODE_HANG);
                        pc_d     = '0;
                    end
                    drain_d = '0;
                    state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_LAST)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE: begin
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            drain_q   <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            trap_q    <= '0;
            idle_q    <= '0;
            code_q    <= '0;
            reason_q  <= NONE;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            idle_q    <= idle_d;
            code_q    <= code_d;
            reason_q  <= reason_d;
            pc_q      <= pc_d;
        end
    end

    assign exit_valid_o  = (state_q == DONE);
    assign exit_code_o   = code_q;
    assign exit_reason_o = reason_q;
    assign exit_pc_o     = pc_q;
    assign cycle_cnt_o   = cycle_q;
    assign instret_o     = instret_q;
    assign trap_cnt_o    = trap_q;

`ifdef RVFI_MON_HISTORY_EN
    logic [NR_COMMIT_PORTS-1:0]       hist_we;
    logic [NR_COMMIT_PORTS-1:0][63:0] hist_wd;

    always_comb begin
        hist_we = '0;
        hist_wd = '0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            hist_we[k] = rvfi_i[k].valid;
            hist_wd[k] = sext_pc(rvfi_i[k].pc_rdata);
        end
    end

    rvfi_pc_history #(
        .DEPTH (HIST_DEPTH),
        .NR_WR (NR_COMMIT_PORTS)
    ) i_hist (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (state_q != DONE),
        .we_i    (hist_we),
        .wdata_i (hist_wd),
        .idx_i   (hist_idx_i),
        .rdata_o (hist_pc_o)
    );
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx_i;
    assign hist_pc_o       = '0;
`endif
endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// Directed bench for rvfi_commit_monitor: counter table plus exit scenarios.
// DUT built with CNT_W=8, HANG_CYCLES=50, DRAIN_CYCLES=16, HIST_DEPTH=8.

module tb_rvfi_commit_monitor;
    import rvfi_mon_pkg::*;

    localparam logic [63:0] TH = 64'h8000_1000;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    rvfi_pkg::rvfi_instr_t [1:0]  rvfi;
    logic [63:0]                  tohost;
    logic [7:0]                   tmo;
    logic                         ev;
    logic [63:0]                  ecode;
    exit_reason_e                 erea;
    logic [63:0]                  epc;
    logic [7:0]                   cyc, inst, trp;
    logic [2:0]                   hidx;
    logic [63:0]                  hpc;

    int chk_cnt = 0;
    int pass_cnt = 0;

    rvfi_commit_monitor #(
        .NR_COMMIT_PORTS (2),
        .CNT_W           (8),
        .HANG_CYCLES     (50),
        .DRAIN_CYCLES    (16),
        .HIST_DEPTH      (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rvfi_i        (rvfi),
        .tohost_addr_i (tohost),
        .timeout_i     (tmo),
        .exit_valid_o  (ev),
        .exit_code_o   (ecode),
        .exit_reason_o (erea),
        .exit_pc_o     (epc),
        .cycle_cnt_o   (cyc),
        .instret_o     (inst),
        .trap_cnt_o    (trp),
        .hist_idx_i    (hidx),
        .hist_pc_o     (hpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v0, v1, t0, t1;
        logic [2:0] st;
        logic [7:0] ei, et;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rvfi = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic ret(input int k, input logic [38:0] pc);
        rvfi[k].valid    = 1'b1;
        rvfi[k].rd_addr  = 5'd1;
        rvfi[k].pc_rdata = pc;
    endtask

    task automatic store(input int k, input logic [38:0] pc,
                         input logic [63:0] a, input logic [63:0] d);
        rvfi[k].valid     = 1'b1;
        rvfi[k].rd_addr   = 5'd0;
        rvfi[k].pc_rdata  = pc;
        rvfi[k].mem_addr  = a;
        rvfi[k].mem_wmask = 8'hff;
        rvfi[k].mem_wdata = d;
    endtask

    // Ticks until exit_valid rises; returns count (bound 60).
    task automatic wait_valid(output int n);
        n = 0;
        while (!ev && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        tohost = TH;
        tmo    = '0;
        hidx   = '0;
        clr();

        vt[0] = '{1,1,0,0,0, 8'd2, 8'd0};
        vt[1] = '{0,1,1,0,0, 8'd3, 8'd1};
        vt[2] = '{1,0,0,1,1, 8'd4, 8'd2};
        vt[3] = '{0,0,1,1,0, 8'd4, 8'd4};
        vt[4] = '{1,1,1,1,2, 8'd6, 8'd4};
        vt[5] = '{1,0,0,0,3, 8'd7, 8'd4};
        vt[6] = '{1,1,0,0,4, 8'd9, 8'd4};
        vt[7] = '{0,0,1,0,5, 8'd9, 8'd5};
        vt[8] = '{0,0,0,0,0, 8'd9, 8'd5};
        vt[9] = '{1,1,0,0,0, 8'd11, 8'd5};

        // Reset state
        reset_dut();
        chk("rst_valid", 64'(ev), 64'd0);
        chk("rst_reason", 64'(erea), 64'(NONE));
        chk("rst_code", ecode, 64'd0);
        chk("rst_pc", epc, 64'd0);
        chk("rst_cycle", 64'(cyc), 64'd0);
        chk("rst_instret", 64'(inst), 64'd0);
        chk("rst_trap", 64'(trp), 64'd0);
        chk("rst_hist", hpc, 64'd0);

        // Counter table with near-miss tohost stores on port 0
        for (int i = 0; i < 10; i++) begin
            clr();
            if (vt[i].v0) ret(0, 39'(64'h100 + 4 * i));
            if (vt[i].v1) ret(1, 39'(64'h200 + 4 * i));
            if (vt[i].st != 3'd0) begin
                store(0, 39'h300, TH, 64'd1);
                rvfi[0].valid = vt[i].v0;
                unique case (vt[i].st)
                    3'd1: rvfi[0].rd_addr = 5'd5;
                    3'd2: rvfi[0].mem_wmask = 8'h00;
                    3'd3: rvfi[0].mem_addr = TH + 64'd8;
                    3'd4: rvfi[0].mem_wdata = 64'd0;
                    default: rvfi[0].valid = 1'b0;
                endcase
            end
            rvfi[0].trap = vt[i].t0;
            rvfi[1].trap = vt[i].t1;
            tick();
            chk($sformatf("tbl%0d_instret", i), 64'(inst), 64'(vt[i].ei));
            chk($sformatf("tbl%0d_trap", i), 64'(trp), 64'(vt[i].et));
            chk($sformatf("tbl%0d_cycle", i), 64'(cyc), 64'(i + 1));
            chk($sformatf("tbl%0d_reason", i), 64'(erea), 64'(NONE));
        end

        // Tohost on port 1
        reset_dut();
        repeat (3) begin
            clr();
            ret(0, 39'h8000_0000);
            tick();
        end
        clr();
        ret(0, 39'h8000_0038);
        store(1, 39'h8000_0040, TH, 64'd1);
        tick();
        clr();
        chk("th1_reason", 64'(erea), 64'(TOHOST));
        chk("th1_code", ecode, 64'd1);
        chk("th1_pc", epc, 64'h8000_0040);
        chk("th1_valid_early", 64'(ev), 64'd0);
        wait_valid(n);
        chk("th1_valid_latency", 64'(n + 1), 64'd17);
        chk("th1_code_held", ecode, 64'd1);

        // Both ports hit tohost; port 0 wins, PC sign-extended
        reset_dut();
        store(0, 39'h40_0000_0100, TH, 64'd3);
        store(1, 39'h8000_0044, TH, 64'd5);
        tick();
        clr();
        chk("th2_code", ecode, 64'd3);
        chk("th2_pc_sext", epc, 64'hffff_ffc0_0000_0100);
        repeat (4) tick();
        // Reset mid-DRAIN
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reason", 64'(erea), 64'(NONE));
        chk("mid_rst_code", ecode, 64'd0);
        chk("mid_rst_pc", epc, 64'd0);
        chk("mid_rst_cycle", 64'(cyc), 64'd0);
        chk("mid_rst_instret", 64'(inst), 64'd0);
        reset_dut();
        store(0, 39'h8000_0080, TH, 64'd9);
        tick();
        clr();
        chk("mid_rst_run", 64'(erea), 64'(TOHOST));
        chk("mid_rst_run_code", ecode, 64'd9);

        // Timeout with tohost disabled (store to address 0 ignored)
        tohost = '0;
        tmo    = 8'd100;
        reset_dut();
        store(0, 39'h10, 64'd0, 64'd1);
        ret(1, 39'h14);
        tick();
        ret(0, 39'h18);
        n = 1;
        while (erea == NONE && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_reason", 64'(erea), 64'(TIMEOUT));
        chk("tmo_code", ecode, 64'd1);
        chk("tmo_pc", epc, 64'd0);
        chk("tmo_cycle_at_latch", 64'(cyc), 64'd101);
        wait_valid(n);
        chk("tmo_drain_len", 64'(n), 64'd16);
        chk("tmo_cycle_done", 64'(cyc), 64'd117);
        chk("tmo_instret", 64'(inst), 64'd234);
        repeat (5) tick();
        chk("tmo_cycle_frozen", 64'(cyc), 64'd117);
        chk("tmo_instret_frozen", 64'(inst), 64'd234);
        clr();
        tmo = '0;

        // Hang after 20 retiring cycles
        reset_dut();
        repeat (20) begin
            clr();
            ret(0, 39'h40);
            tick();
        end
        clr();
        n = 0;
        while (erea == NONE && n < 100) begin
            tick();
            n++;
        end
        chk("hang_latency", 64'(n), 64'd51);
        chk("hang_reason", 64'(erea), 64'(HANG));
        chk("hang_code", ecode, 64'd3);
        tohost = TH;
        repeat (2) begin
            store(0, 39'h8000_0100, TH, 64'd7);
            tick();
        end
        clr();
        chk("hang_drain_reason", 64'(erea), 64'(HANG));
        chk("hang_drain_code", ecode, 64'd3);
        chk("hang_drain_pc", epc, 64'd0);
        chk("hang_drain_instret", 64'(inst), 64'd22);
        wait_valid(n);
        chk("hang_drain_rest", 64'(n), 64'd14);
        ret(0, 39'h44);
        ret(1, 39'h48);
        repeat (3) tick();
        clr();
        chk("hang_done_instret", 64'(inst), 64'd22);
        chk("hang_done_cycle", 64'(cyc), 64'd87);
        chk("hang_done_valid", 64'(ev), 64'd1);

        // Saturation of all counters
        tohost = '0;
        reset_dut();
        ret(0, 39'h50);
        rvfi[1].trap = 1'b1;
        repeat (300) tick();
        clr();
        chk("sat_cycle", 64'(cyc), 64'hff);
        chk("sat_instret", 64'(inst), 64'hff);
        chk("sat_trap", 64'(trp), 64'hff);
        chk("sat_reason", 64'(erea), 64'(NONE));

        // PC history
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            clr();
            ret(0, 39'(8 * i));
            ret(1, 39'(8 * i + 4));
            tick();
        end
        clr();
`ifdef RVFI_MON_HISTORY_EN
        hidx = 3'd0;
        #1;
        chk("hist_idx0", hpc, 64'h24);
        hidx = 3'd1;
        #1;
        chk("hist_idx1", hpc, 64'h20);
        hidx = 3'd7;
        #1;
        chk("hist_idx7", hpc, 64'h8);
`else
        hidx = 3'd0;
        #1;
        chk("hist_off_idx0", hpc, 64'd0);
        hidx = 3'd7;
        #1;
        chk("hist_off_idx7", hpc, 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
